// File: rtl/vga_sched_pkg.sv
// Shared types for the VGA SRAM scheduler: fetch FSM states, grant encoding, SRAM timing.
package vga_sched_pkg;

  typedef enum logic [0:0] {
    F_IDLE  = 1'b0,
    F_FETCH = 1'b1
  } fetch_state_e;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_DISP = 2'd1,
    G_CPU  = 2'd2
  } grant_e;

  localparam int SRAM_RD_LAT = 1;

endpackage

// File: rtl/vga_sched_fifo.sv
// Show-ahead display prefetch FIFO; head word is registered so it holds across empty pops.
// Flush has priority over push and pop in the same cycle.
module vga_sched_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [15:0]      push_dat_i,
  input  logic             pop_i,
  output logic [15:0]      dat_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic [15:0]      head_q, head_d;
  logic             do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    cnt_d         = cnt_q;
    head_d        = head_q;
    cnt_after_pop = cnt_q - CNT_W'(do_pop);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d = cnt_after_pop + CNT_W'(push_i);
      // An entry left after the pop is already in memory; otherwise the push becomes head.
      if (cnt_after_pop != '0) begin
        head_d = mem_q[rd_ptr_d];
      end else if (push_i) begin
        head_d = push_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign dat_o   = head_q;
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/vga_sram_sched.sv
// Shares one 16-bit synchronous SRAM between Wishbone CPU accesses and CRT line prefetch;
// display wins by default, a starvation counter bounds CPU latency.
module vga_sram_sched
  import vga_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [17:1] wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_stb_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        disp_start_i,
  input  logic [17:1] disp_adr_i,
  input  logic [7:0]  disp_words_i,
  input  logic        disp_rd_i,
  output logic [15:0] disp_dat_o,
  output logic        disp_empty_o,
  output logic        disp_underrun_o,
  output logic [17:1] sram_adr_o,
  output logic [1:0]  sram_sel_o,
  output logic        sram_we_o,
  output logic [15:0] sram_dat_o,
  input  logic [15:0] sram_dat_i
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int LAT   = SRAM_RD_LAT;

  fetch_state_e     fsm_q, fsm_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [17:1]      fetch_adr_q, fetch_adr_d;
  logic [7:0]       starve_q, starve_d;
  logic [LAT-1:0]   disp_vld_q, disp_stale_q, cpu_vld_q, cpu_rd_q;
  logic             underrun_q;
  logic [17:1]      sram_adr_q;
  logic [1:0]       sram_sel_q;
  logic             sram_we_q;
  logic [15:0]      sram_dat_q;

  grant_e           gnt;
  logic [CNT_W-1:0] fifo_cnt;
  logic [OCC_W-1:0] occ;
  logic             fifo_empty, fifo_push, fifo_pop;
  logic             disp_elig, cpu_elig, starved;

  // In-flight display reads consume credits just like FIFO entries.
  assign occ       = OCC_W'(fifo_cnt) + OCC_W'($countones(disp_vld_q));
  assign disp_elig = (fsm_q == F_FETCH) && (remaining_q != 8'd0) && (occ < OCC_W'(FIFO_DEPTH));
  assign cpu_elig  = wb_stb_i && !(|cpu_vld_q);
  assign starved   = (starve_q == 8'(STARVE_MAX));

  always_comb begin
    gnt = G_NONE;
    if (disp_elig && !(cpu_elig && starved)) begin
      gnt = G_DISP;
    end else if (cpu_elig) begin
      gnt = G_CPU;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    remaining_d = remaining_q;
    fetch_adr_d = fetch_adr_q;
    if (gnt == G_DISP) begin
      fetch_adr_d = fetch_adr_q + 17'd1;
      remaining_d = remaining_q - 8'd1;
      if (remaining_q == 8'd1) fsm_d = F_IDLE;
    end
    if (disp_start_i) begin
      fetch_adr_d = disp_adr_i;
      remaining_d = disp_words_i;
      if (disp_words_i != 8'd0) begin
        fsm_d = F_FETCH;
      end else begin
        fsm_d = F_IDLE;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!wb_stb_i || (gnt == G_CPU)) begin
      starve_d = 8'd0;
    end else if ((gnt == G_DISP) && cpu_elig && !starved) begin
      starve_d = starve_q + 8'd1;
    end
  end

  assign fifo_push = disp_vld_q[LAT-1] && !disp_stale_q[LAT-1];
  assign fifo_pop  = disp_rd_i && !fifo_empty;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      fsm_q        <= F_IDLE;
      remaining_q  <= 8'd0;
      fetch_adr_q  <= '0;
      starve_q     <= 8'd0;
      disp_vld_q   <= '0;
      disp_stale_q <= '0;
      cpu_vld_q    <= '0;
      cpu_rd_q     <= '0;
      underrun_q   <= 1'b0;
      sram_adr_q   <= '0;
      sram_sel_q   <= 2'b00;
      sram_we_q    <= 1'b0;
      sram_dat_q   <= 16'h0000;
    end else begin
      fsm_q        <= fsm_d;
      remaining_q  <= remaining_d;
      fetch_adr_q  <= fetch_adr_d;
      starve_q     <= starve_d;
      // A line start poisons everything already issued, including this cycle's grant.
      disp_vld_q   <= LAT'({disp_vld_q, gnt == G_DISP});
      disp_stale_q <= LAT'({disp_stale_q | {LAT{disp_start_i}}, disp_start_i});
      cpu_vld_q    <= LAT'({cpu_vld_q, gnt == G_CPU});
      cpu_rd_q     <= LAT'({cpu_rd_q, (gnt == G_CPU) && !wb_we_i});
      if (disp_start_i) begin
        underrun_q <= 1'b0;
      end else if (disp_rd_i && fifo_empty) begin
        underrun_q <= 1'b1;
      end
      case (gnt)
        G_CPU: begin
          sram_adr_q <= wb_adr_i;
          sram_sel_q <= wb_sel_i;
          sram_we_q  <= wb_we_i;
          sram_dat_q <= wb_dat_i;
        end
        G_DISP: begin
          sram_adr_q <= fetch_adr_q;
          sram_sel_q <= 2'b11;
          sram_we_q  <= 1'b0;
        end
        default: sram_we_q <= 1'b0;
      endcase
    end
  end

  vga_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_rst_i),
    .flush_i    (disp_start_i),
    .push_i     (fifo_push),
    .push_dat_i (sram_dat_i),
    .pop_i      (fifo_pop),
    .dat_o      (disp_dat_o),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  assign wb_ack_o        = cpu_vld_q[LAT-1];
  assign wb_dat_o        = cpu_rd_q[LAT-1] ? sram_dat_i : 16'h0000;
  assign disp_empty_o    = fifo_empty;
  assign disp_underrun_o = underrun_q;
  assign sram_adr_o      = sram_adr_q;
  assign sram_sel_o      = sram_sel_q;
  assign sram_we_o       = sram_we_q;
  assign sram_dat_o      = sram_dat_q;

endmodule

// File: doc/vga_sram_sched.md
# vga_sram_sched

Single-port video SRAM scheduler for the VGA core. Shares one 16-bit synchronous SRAM between the CPU-side Wishbone memory path and the CRT display fetch. Display words are prefetched into a small FIFO so the pixel pipeline never waits on the SRAM. A starvation counter guarantees that CPU accesses make forward progress during active display.

## Interface
Parameters:
- FIFO_DEPTH, 4: display prefetch FIFO entries; power of two, minimum 2.
- STARVE_MAX, 8: consecutive display grants allowed while a CPU request is pending; range 1..255.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_i  in  1  reset; synchronous, active-low (0 = reset).
- wb_adr_i  in  17 [17:1]  CPU word address.
- wb_sel_i  in  2  CPU byte lanes.
- wb_we_i  in  1  CPU write enable.
- wb_dat_i  in  16  CPU write data.
- wb_stb_i  in  1  CPU request; held high until wb_ack_o.
- wb_dat_o  out  16  CPU read data; valid while wb_ack_o is high.
- wb_ack_o  out  1  one-cycle acknowledge.
- disp_start_i  in  1  line-start pulse; loads disp_adr_i and disp_words_i.
- disp_adr_i  in  17 [17:1]  first word address of the line.
- disp_words_i  in  8  words to fetch for the line; 0 means no fetch.
- disp_rd_i  in  1  pop one word from the FIFO.
- disp_dat_o  out  16  FIFO head word (show-ahead).
- disp_empty_o  out  1  FIFO empty.
- disp_underrun_o  out  1  sticky flag: a pop was attempted while the FIFO was empty.
- sram_adr_o  out  17 [17:1], sram_sel_o out 2, sram_we_o out 1, sram_dat_o out 16  SRAM command; all registered.
- sram_dat_i  in  16  SRAM read data, valid exactly one cycle after the command.

## Operation
- Slot model: one SRAM command per cycle, registered on sram_*_o. Read data returns one cycle later.
- Display eligibility: remaining words > 0 AND credits > 0, where credits = FIFO_DEPTH − occupancy − in-flight display reads.
- CPU eligibility: wb_stb_i high AND no CPU access already in flight.
- Arbitration each cycle: display wins by default. CPU wins when starve_cnt == STARVE_MAX, or when display is not eligible.
- starve_cnt increments on each display grant while a CPU request is pending. It clears on any CPU grant and whenever wb_stb_i is low. It saturates at STARVE_MAX.
- Fetch FSM states:
  - F_IDLE: remaining == 0.
  - F_FETCH: remaining > 0. Each display grant issues a read of fetch_adr, increments fetch_adr (mod 2^17) and decrements remaining. When remaining reaches 0, return to F_IDLE.
- disp_start_i, in any state:
  - flush the FIFO;
  - mark any in-flight display read stale (it is discarded on return);
  - load fetch_adr and remaining;
  - clear disp_underrun_o;
  - enter F_FETCH if disp_words_i != 0, else F_IDLE.
  - A display grant in that same cycle uses the old address but is tagged stale.
- CPU access:
  - Granted cycle: command issued with wb_adr_i, wb_sel_i, wb_we_i, wb_dat_i.
  - Next cycle: wb_ack_o = 1; for reads, wb_dat_o = sram_dat_i captured.
  - Writes are acknowledged on the same schedule.
  - wb_stb_i may stay high in the ack cycle; the CPU is not eligible again until the cycle after the ack.
- FIFO:
  - Push on the return of a non-stale display read.
  - Pop on disp_rd_i & !disp_empty_o.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Overflow cannot occur because of credits.
  - disp_rd_i while empty: FIFO unchanged, disp_dat_o holds its value, disp_underrun_o set.
- Idle slots: sram_we_o = 0; address and data hold their previous values.

## Timing
- Reset values: wb_ack_o 0, wb_dat_o 0, sram_adr_o 0, sram_sel_o 0, sram_we_o 0, sram_dat_o 0, disp_dat_o 0, disp_empty_o 1, disp_underrun_o 0. Internal state: FSM F_IDLE, remaining 0, starve_cnt 0, FIFO empty, no reads in flight.
- Reset mid-access: in-flight returns are ignored and no ack is produced.
- CPU latency, uncontended: wb_stb_i rises in cycle N, command in N, ack in N+1.
- CPU worst-case latency under display load: STARVE_MAX + 2 cycles.
- Display latency: disp_start_i in N, first read command in N+1, first word visible (disp_empty_o = 0) in N+3.
- Sustained display rate: 1 word/cycle when the CPU is idle and the FIFO is drained at ≥ 1 word/cycle.

## Structure
- Package vga_sched_pkg:
  - fetch FSM state enum (F_IDLE, F_FETCH);
  - grant encoding (G_NONE, G_DISP, G_CPU);
  - SRAM read latency constant (1).
- Sub-module vga_sched_fifo: synchronous show-ahead FIFO parameterised by FIFO_DEPTH, with flush, push, pop, empty and count outputs.
- The top level holds the arbiter, the fetch FSM, starve_cnt and the in-flight tag pipeline.

## Test plan
- CPU only: write 16'hBEEF to 17'h00010 with sel 2'b11, then read it back → each ack 1 cycle after stb; read returns 16'hBEEF.
- Line fetch: disp_start_i with adr 17'h1FFFE and words 4, SRAM preloaded with the address pattern → FIFO yields the words from 1FFFE, 1FFFF, 00000, 00001 (address wraps), then F_IDLE. Exactly 4 reads are issued.
- Starvation: STARVE_MAX = 3, words = 200, continuous pops, CPU read held → ack within 5 cycles, then display resumes.
- Backpressure: words = 10, no pops → exactly FIFO_DEPTH reads are issued and then fetching stalls. After one pop, exactly one further read is issued.
- Restart: disp_start_i issued mid-fetch with a read in flight → the stale word never appears. The first word out is from the new address; underrun is cleared.
- Underrun and reset: pop while empty → disp_underrun_o = 1. Drive wb_rst_i = 0 during a CPU read → no ack is produced and all outputs take their reset values.
